ram_stream_reader: RTL and testbench

Read-side master for the team's dual-port `ram` block. On a start command it sweeps a contiguous address window on one RAM port and streams the words out on a valid/ready interface. The RAM's read latency is absorbed internally, and full back-pressure is supported without losing or duplicating words. It sits between a `ram` instance and any downstream stream consumer, such as a serializer or DMA egress.

---
 rtl/ram_stream_reader.sv | 201 ++++++++++++++++++++
 tb/tb_ram_stream_reader.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
// -----------------
// Read-side master for the dual-port `ram` block. On an accepted start it
// sweeps the address window base_addr .. base_addr+len_m1 (wrapping modulo
// 2^ADDR_WDT) on one RAM port and streams the words out on a valid/ready
// interface. A 2-entry output FIFO with credit-based issue absorbs the RAM
// read latency (RD_LAT = 0 or 1) and full back-pressure.
//
// Parameters:
//   ADDR_WDT  RAM address width (must match the attached ram)
//   DATA_WDT  RAM data width (must match the attached ram)
//   RD_LAT    RAM read latency, 0 or 1 (must equal the ram DOUT_REG setting)
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             launch a sweep (only honoured in IDLE)
//   base_addr, len_m1 first address and word count minus one, taken with start
//   busy, done        sweep in progress / one-cycle completion pulse
//   ram_addr, ram_we, ram_din, ram_dout   RAM port (read-only use)
//   m_data, m_valid, m_ready, m_last      output stream
//   sum               (only with RAM_RD_SUM_EN) modulo sum of streamed words
//
// Optional feature macro: RAM_RD_SUM_EN adds the `sum` output and its adder.

module ram_stream_reader #(
    parameter int ADDR_WDT = 10,
    parameter int DATA_WDT = 8,
    parameter int RD_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_WDT-1:0] base_addr,
    input  logic [ADDR_WDT-1:0] len_m1,
    output logic                busy,
    output logic                done,
    output logic [ADDR_WDT-1:0] ram_addr,
    output logic                ram_we,
    output logic [DATA_WDT-1:0] ram_din,
    input  logic [DATA_WDT-1:0] ram_dout,
    output logic [DATA_WDT-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last
`ifdef RAM_RD_SUM_EN
    ,
    output logic [DATA_WDT-1:0] sum
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [ADDR_WDT-1:0] ADDR_ONE = 1;

    logic [1:0]          state;
    logic [ADDR_WDT-1:0] addr;
    logic [ADDR_WDT-1:0] len_reg;
    logic [ADDR_WDT-1:0] issue_cnt;

    logic accept;
    logic issue;
    logic issue_last;
    logic issue_d1;
    logic last_d1;
    logic cap;
    logic cap_last;
    logic pop;
    logic can_issue;

    logic [DATA_WDT-1:0] fifo_data [2];
    logic                fifo_last [2];
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          occ;
    logic [2:0]          committed;

    // A start in the done cycle must not relaunch, even though state is
    // already back in IDLE at that point.
    assign accept = (state == IDLE) && start && !done;
    assign busy   = (state != IDLE);

    assign ram_addr = addr;
    assign ram_we   = 1'b0;
    assign ram_din  = '0;

    assign m_valid = (occ != 2'd0);
    assign m_data  = fifo_data[rd_ptr];
    assign m_last  = m_valid && fifo_last[rd_ptr];
    assign pop     = m_valid && m_ready;

    // Words already committed to the FIFO: those stored plus the read whose
    // data lands at this edge (only exists when the RAM output is registered).
    // A new read is allowed only if, after this cycle's pop, there is still a
    // free slot waiting for it, so the FIFO can never overflow.
    assign committed  = {1'b0, occ} + ((RD_LAT == 0) ? 3'd0 : {2'b00, issue_d1});
    assign can_issue  = committed < (3'd2 + {2'b00, pop});
    assign issue      = (state == RUN) && can_issue;
    assign issue_last = (issue_cnt == len_reg);

    // Capture point: same edge as the issue for a combinational RAM, one edge
    // later for a registered RAM.
    assign cap      = (RD_LAT == 0) ? issue : issue_d1;
    assign cap_last = (RD_LAT == 0) ? (issue && issue_last) : last_d1;

    // Sweep control: address/counter stepping and the IDLE/RUN/DRAIN sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            len_reg   <= '0;
            issue_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr      <= base_addr;
                        len_reg   <= len_m1;
                        issue_cnt <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr <= addr + ADDR_ONE;
                        if (issue_last) begin
                            state <= DRAIN;
                        end else begin
                            issue_cnt <= issue_cnt + ADDR_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tracks the read that is inside a registered RAM for one cycle, together
    // with whether it is the final word of the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_d1 <= 1'b0;
            last_d1  <= 1'b0;
        end else begin
            issue_d1 <= issue;
            last_d1  <= issue && issue_last;
        end
    end

    // Two-entry output FIFO; the head entry drives the stream so data and
    // last stay put for as long as the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last[0] <= 1'b0;
            fifo_last[1] <= 1'b0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            occ          <= 2'd0;
        end else begin
            if (cap) begin
                fifo_data[wr_ptr] <= ram_dout;
                fifo_last[wr_ptr] <= cap_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({cap, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef RAM_RD_SUM_EN
    // Running modulo sum of delivered words; holds after done until the next
    // accepted start clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (accept) begin
            sum <= '0;
        end else if (pop) begin
            sum <= sum + m_data;
        end
    end
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Testbench for ram_stream_reader. Two instances share one clock and reset:
// dut1 runs against a registered RAM model (RD_LAT = 1), dut0 against a
// combinational one (RD_LAT = 0). Expected words are queued when a sweep is
// launched and checked as each transfer happens.

module tb_ram_stream_reader;

    localparam int AW = 10;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic          s1_start, s1_busy, s1_done, s1_we, s1_valid, s1_ready, s1_last;
    logic [AW-1:0] s1_base, s1_len, s1_addr;
    logic [DW-1:0] s1_din, s1_dout, s1_data;

    logic          s0_start, s0_busy, s0_done, s0_we, s0_valid, s0_ready, s0_last;
    logic [AW-1:0] s0_base, s0_len, s0_addr;
    logic [DW-1:0] s0_din, s0_dout, s0_data;

`ifdef RAM_RD_SUM_EN
    logic [DW-1:0] s1_sum, s0_sum;
    logic [DW-1:0] exp_sum1;
`endif

    int checks = 0;
    int errors = 0;

    // scoreboards hold {last, data}
    logic [DW:0] q1[$];
    logic [DW:0] q0[$];
    int rx1 = 0;
    int rx0 = 0;
    int done_cnt1 = 0;
    int done_cnt0 = 0;

    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // RAM models with mem[i] = i
    logic [DW-1:0] mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
    end
    always @(posedge clk) s1_dout <= mem[s1_addr];
    assign s0_dout = mem[s0_addr];

    ram_stream_reader #(.ADDR_WDT(AW), .DATA_WDT(DW), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start),
        .base_addr(s1_base), .len_m1(s1_len),
        .busy(s1_busy), .done(s1_done),
        .ram_addr(s1_addr), .ram_we(s1_we), .ram_din(s1_din), .ram_dout(s1_dout),
        .m_data(s1_data), .m_valid(s1_valid), .m_ready(s1_ready), .m_last(s1_last)
`ifdef RAM_RD_SUM_EN
        , .sum(s1_sum)
`endif
    );

    ram_stream_reader #(.ADDR_WDT(AW), .DATA_WDT(DW), .RD_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(s0_start),
        .base_addr(s0_base), .len_m1(s0_len),
        .busy(s0_busy), .done(s0_done),
        .ram_addr(s0_addr), .ram_we(s0_we), .ram_din(s0_din), .ram_dout(s0_dout),
        .m_data(s0_data), .m_valid(s0_valid), .m_ready(s0_ready), .m_last(s0_last)
`ifdef RAM_RD_SUM_EN
        , .sum(s0_sum)
`endif
    );

    // dut1 stream monitor: scoreboard pop and stall-stability check
    logic        p1_stall = 1'b0;
    logic [DW:0] p1_word;
    logic [DW:0] e1;
    always @(negedge clk) begin
        if (!rst_n) begin
            p1_stall = 1'b0;
        end else begin
            if (p1_stall) begin
                checks++;
                if ({s1_valid, s1_last, s1_data} !== {1'b1, p1_word}) begin
                    errors++;
                    $display("[TB] FAIL dut1_stall_hold got valid=%0b last/data=%h expected valid=1 last/data=%h",
                             s1_valid, {s1_last, s1_data}, p1_word);
                end
            end
            if (s1_done) done_cnt1++;
            if (s1_valid && s1_ready) begin
                checks++;
                rx1++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL dut1_extra_word got last/data=%h expected no transfer", {s1_last, s1_data});
                end else begin
                    e1 = q1.pop_front();
                    if ({s1_last, s1_data} !== e1) begin
                        errors++;
                        $display("[TB] FAIL dut1_word got last/data=%h expected %h", {s1_last, s1_data}, e1);
                    end
                end
            end
            p1_stall = s1_valid && !s1_ready;
            p1_word  = {s1_last, s1_data};
        end
    end

    // dut0 stream monitor
    logic [DW:0] e0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (s0_done) done_cnt0++;
            if (s0_valid && s0_ready) begin
                checks++;
                rx0++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL dut0_extra_word got last/data=%h expected no transfer", {s0_last, s0_data});
                end else begin
                    e0 = q0.pop_front();
                    if ({s0_last, s0_data} !== e0) begin
                        errors++;
                        $display("[TB] FAIL dut0_word got last/data=%h expected %h", {s0_last, s0_data}, e0);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Queue expected words for dut1 and launch its sweep; returns just after
    // the edge that samples start.
    task automatic start1(input logic [AW-1:0] base, input logic [AW-1:0] len);
        logic [AW-1:0] a;
`ifdef RAM_RD_SUM_EN
        exp_sum1 = '0;
`endif
        for (int i = 0; i <= int'(len); i++) begin
            a = base + AW'(i);
            q1.push_back({(i == int'(len)), a[DW-1:0]});
`ifdef RAM_RD_SUM_EN
            exp_sum1 = exp_sum1 + a[DW-1:0];
`endif
        end
        @(posedge clk); #1;
        s1_base = base; s1_len = len; s1_start = 1'b1;
        @(posedge clk); #1;
        s1_start = 1'b0;
    endtask

    task automatic start0(input logic [AW-1:0] base, input logic [AW-1:0] len);
        logic [AW-1:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = base + AW'(i);
            q0.push_back({(i == int'(len)), a[DW-1:0]});
        end
        @(posedge clk); #1;
        s0_base = base; s0_len = len; s0_start = 1'b1;
        @(posedge clk); #1;
        s0_start = 1'b0;
    endtask

    // Step cycles after the start edge, driving m_ready (mode 1 = toggling
    // pattern) and an optional stray start, recording the first m_valid cycle
    // and the done cycle (-1 if never seen within the budget).
    task automatic run_sweep(input int sel, input int mode, input int inject, input int budget,
                             output int first_v, output int done_at);
        logic v, d;
        first_v = -1;
        done_at = -1;
        for (int c = 0; c <= budget && done_at < 0; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (sel == 1) begin
                s1_ready = (mode == 1) ? pat[c % 6] : 1'b1;
                s1_start = (c == inject);
                if (c == inject) begin
                    s1_base = 10'h300;
                    s1_len  = 10'd7;
                end
                v = s1_valid;
                d = s1_done;
            end else begin
                s0_ready = 1'b1;
                v = s0_valid;
                d = s0_done;
            end
            if (v && first_v < 0) first_v = c;
            if (d) done_at = c;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s1_start = 0; s1_base = '0; s1_len = '0; s1_ready = 0;
        s0_start = 0; s0_base = '0; s0_len = '0; s0_ready = 0;
        @(posedge clk); #1;
        checks++;
        if ({s1_busy, s1_done, s1_valid, s1_last, s1_we} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl1 got %b expected 00000", {s1_busy, s1_done, s1_valid, s1_last, s1_we});
        end
        checks++;
        if ({s1_addr, s1_data, s1_din} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data1 got addr=%h data=%h din=%h expected 0", s1_addr, s1_data, s1_din);
        end
        checks++;
        if ({s0_busy, s0_done, s0_valid, s0_last, s0_we} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl0 got %b expected 00000", {s0_busy, s0_done, s0_valid, s0_last, s0_we});
        end
        checks++;
        if ({s0_addr, s0_data, s0_din} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data0 got addr=%h data=%h din=%h expected 0", s0_addr, s0_data, s0_din);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int fv, da, rb;
        rb = rx1;
        s1_ready = 1'b1;
        start1(10'h010, 10'd3);
        checks++;
        if (s1_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_busy got %b expected 1", s1_busy);
        end
        run_sweep(1, 0, -1, 40, fv, da);
        checks++;
        if (fv != 2) begin
            errors++;
            $display("[TB] FAIL basic_first_valid got cycle %0d expected 2", fv);
        end
        checks++;
        if (da != 6) begin
            errors++;
            $display("[TB] FAIL basic_done_cycle got %0d expected 6", da);
        end
        checks++;
        if (s1_busy !== 1'b0 || rx1 - rb != 4 || q1.size() != 0) begin
            errors++;
            $display("[TB] FAIL basic_complete got busy=%b words=%0d left=%0d expected busy=0 words=4 left=0",
                     s1_busy, rx1 - rb, q1.size());
        end
`ifdef RAM_RD_SUM_EN
        checks++;
        if (s1_sum !== 8'h46) begin
            errors++;
            $display("[TB] FAIL basic_sum got %h expected 46", s1_sum);
        end
`endif
        @(posedge clk); #1;
        checks++;
        if (s1_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done_pulse got %b expected 0", s1_done);
        end
    endtask

    task automatic test_wrap();
        int fv, da, rb;
        rb = rx1;
        s1_ready = 1'b1;
        start1(10'h3FE, 10'd3);
        run_sweep(1, 0, -1, 40, fv, da);
        checks++;
        if (da != 6 || rx1 - rb != 4 || q1.size() != 0) begin
            errors++;
            $display("[TB] FAIL wrap_complete got done=%0d words=%0d left=%0d expected done=6 words=4 left=0",
                     da, rx1 - rb, q1.size());
        end
    endtask

    task automatic test_back_pressure();
        int fv, da, rb;
        rb = rx1;
        s1_ready = 1'b1;
        start1(10'h123, 10'd15);
        run_sweep(1, 1, -1, 120, fv, da);
        checks++;
        if (da < 0 || rx1 - rb != 16 || q1.size() != 0) begin
            errors++;
            $display("[TB] FAIL bp_complete got done=%0d words=%0d left=%0d expected done>=0 words=16 left=0",
                     da, rx1 - rb, q1.size());
        end
`ifdef RAM_RD_SUM_EN
        checks++;
        if (s1_sum !== exp_sum1) begin
            errors++;
            $display("[TB] FAIL bp_sum got %h expected %h", s1_sum, exp_sum1);
        end
`endif
        s1_ready = 1'b1;
    endtask

    task automatic test_rdlat0();
        int fv, da, rb;
        rb = rx0;
        s0_ready = 1'b1;
        start0(10'h040, 10'd7);
        run_sweep(0, 0, -1, 40, fv, da);
        checks++;
        if (fv != 1) begin
            errors++;
            $display("[TB] FAIL lat0_first_valid got cycle %0d expected 1", fv);
        end
        checks++;
        if (da != 9) begin
            errors++;
            $display("[TB] FAIL lat0_done_cycle got %0d expected 9", da);
        end
        checks++;
        if (s0_busy !== 1'b0 || rx0 - rb != 8 || q0.size() != 0) begin
            errors++;
            $display("[TB] FAIL lat0_complete got busy=%b words=%0d left=%0d expected busy=0 words=8 left=0",
                     s0_busy, rx0 - rb, q0.size());
        end
    endtask

    task automatic test_start_ignored();
        int fv, da, db;
        db = done_cnt1;
        s1_ready = 1'b1;
        start1(10'h200, 10'd5);
        run_sweep(1, 0, 2, 40, fv, da);
        checks++;
        if (da != 8 || q1.size() != 0) begin
            errors++;
            $display("[TB] FAIL busy_start_done got done=%0d left=%0d expected done=8 left=0", da, q1.size());
        end
        // start raised in the done cycle must also be ignored
        s1_base = 10'h050; s1_len = 10'd2; s1_start = 1'b1;
        @(posedge clk); #1;
        s1_start = 1'b0;
        checks++;
        if (s1_busy !== 1'b0 || s1_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_cycle_start got busy=%b valid=%b expected busy=0 valid=0", s1_busy, s1_valid);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (s1_busy !== 1'b0 || done_cnt1 - db != 1) begin
            errors++;
            $display("[TB] FAIL ignored_idle got busy=%b dones=%0d expected busy=0 dones=1", s1_busy, done_cnt1 - db);
        end
    endtask

    task automatic test_reset_mid();
        int fv, da, rb, db;
        rb = rx1;
        s1_ready = 1'b1;
        start1(10'h080, 10'd9);
        for (int c = 0; c < 30 && rx1 - rb < 3; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (rx1 - rb != 3) begin
            errors++;
            $display("[TB] FAIL mid_words_before got %0d expected 3", rx1 - rb);
        end
        db = done_cnt1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s1_busy, s1_done, s1_valid, s1_last} !== 4'b0 || s1_addr !== '0 || s1_data !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs got ctrl=%b addr=%h data=%h expected all 0",
                     {s1_busy, s1_done, s1_valid, s1_last}, s1_addr, s1_data);
        end
        q1.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done_cnt1 != db || s1_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_no_done got dones=%0d busy=%b expected dones=0 busy=0", done_cnt1 - db, s1_busy);
        end
        rb = rx1;
        start1(10'h0F0, 10'd4);
        run_sweep(1, 0, -1, 40, fv, da);
        checks++;
        if (da != 7 || rx1 - rb != 5 || q1.size() != 0) begin
            errors++;
            $display("[TB] FAIL mid_restart got done=%0d words=%0d left=%0d expected done=7 words=5 left=0",
                     da, rx1 - rb, q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_pressure();
        test_rdlat0();
        test_start_ignored();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
